ber_checker: RTL

//  Bit-error-rate checker that sits downstream of the QPSK tx/channel/rx slicer.
//  It takes the recovered bit stream and the PRBS reference stream (same prbs

---
 rtl/ber_checker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - BER checker: exhaustive latency search against a PRBS reference, then error counting
// Finds the rx/ref offset with the fewest mismatches over one window per offset, locks, and counts errors.
module ber_checker #(
  parameter int MAX_DLY    = 511,
  parameter int SEARCH_LEN = 511,
  parameter int CNT_W      = 32,
  parameter int DLY_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ref_bit,
  input  logic             rx_bit,
  input  logic             restart,
  output logic             locked,
  output logic [DLY_W-1:0] delay_out,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int SC_W = $clog2(SEARCH_LEN + 1);
  localparam logic [SC_W-1:0]  LAST_SYM = SC_W'(SEARCH_LEN - 1);
  localparam logic [DLY_W-1:0] LAST_OFF = DLY_W'(MAX_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [MAX_DLY-1:0] sr_q, sr_d;
  logic [DLY_W-1:0]   offset_q, offset_d;
  logic [SC_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [SC_W-1:0]    acc_err_q, acc_err_d;
  logic [SC_W-1:0]    best_err_q, best_err_d;
  logic [DLY_W-1:0]   best_dly_q, best_dly_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  // hist[d] is the reference bit from d enables ago; hist[0] is the current one
  logic [MAX_DLY:0]   hist;
  logic               mis_search;
  logic               mis_locked;
  logic [SC_W-1:0]    win_err;
  logic               new_best;

  assign hist       = {sr_q, ref_bit};
  assign mis_search = rx_bit ^ hist[offset_q];
  assign mis_locked = rx_bit ^ hist[dly_q];
  assign win_err    = acc_err_q + {{(SC_W-1){1'b0}}, mis_search};
  assign new_best   = (win_err < best_err_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_SEARCH;
      sr_q       <= '0;
      offset_q   <= '0;
      sym_cnt_q  <= '0;
      acc_err_q  <= '0;
      best_err_q <= '1;
      best_dly_q <= '0;
      dly_q      <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      offset_q   <= offset_d;
      sym_cnt_q  <= sym_cnt_d;
      acc_err_q  <= acc_err_d;
      best_err_q <= best_err_d;
      best_dly_q <= best_dly_d;
      dly_q      <= dly_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    offset_d   = offset_q;
    sym_cnt_d  = sym_cnt_q;
    acc_err_d  = acc_err_q;
    best_err_d = best_err_q;
    best_dly_d = best_dly_q;
    dly_d      = dly_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (enable) begin
      sr_d = hist[MAX_DLY-1:0];
    end

    // restart keeps the reference history so the new search sees real data at once
    if (restart) begin
      state_d    = S_SEARCH;
      offset_d   = '0;
      sym_cnt_d  = '0;
      acc_err_d  = '0;
      best_err_d = '1;
      best_dly_d = '0;
      dly_d      = '0;
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
    end else if (enable) begin
      case (state_q)
        S_SEARCH: begin
          if (sym_cnt_q == LAST_SYM) begin
            sym_cnt_d = '0;
            acc_err_d = '0;
            if (win_err == '0) begin
              state_d = S_LOCKED;
              dly_d   = offset_q;
            end else begin
              if (new_best) begin
                best_err_d = win_err;
                best_dly_d = offset_q;
              end
              if (offset_q == LAST_OFF) begin
                state_d = S_LOCKED;
                dly_d   = new_best ? offset_q : best_dly_q;
              end else begin
                offset_d = offset_q + DLY_W'(1);
              end
            end
          end else begin
            sym_cnt_d = sym_cnt_q + SC_W'(1);
            acc_err_d = win_err;
          end
        end
        S_LOCKED: begin
          if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (mis_locked && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_comb begin
    locked    = (state_q == S_LOCKED);
    delay_out = dly_q;
    bit_count = bit_cnt_q;
    err_count = err_cnt_q;
  end

endmodule
